decode_stage: RTL

- Registered instruction-decode stage for the five-stage RV32 pipeline, sitting between the IF/ID and ID/EX boundaries.
- Cracks the instruction, generates the immediate and produces ALU and datapath control.
- Owns load-use hazard detection, flush and valid/ready handshaking.
- Generalises the combinational control block: parametrised width, optional M-extension mode, illegal-instruction detection, and a stall performance counter.
- Branch outcome is not resolved here; the branch type is forwarded to EX.

---
 rtl/rv_pkg.sv | 60 ++++++
 rtl/imm_gen.sv | 31 +++
 rtl/decode_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32/64 decode constants, ALU/writeback codes and instruction formats
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // alu_sel = {m_op, alt, funct3}
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // Unknown opcodes fall back to I so hazard checks still consider rs1.
  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_REG:             return FMT_R;
      OP_STORE:           return FMT_S;
      OP_BRANCH:          return FMT_B;
      OP_LUI, OP_AUIPC:   return FMT_U;
      OP_JAL:             return FMT_J;
      default:            return FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate extraction per instruction format, sign-extended to XLEN
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^inst[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV decode stage with load-use stall, flush and handshake
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ENABLE_M      = 0,
  parameter int HAZARD_DETECT = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       alu_sel,
  output logic             b_sel,
  output logic             pc_reg1_sel,
  output logic             rs2_shamt_sel,
  output logic             is_branch,
  output logic             is_jump,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  fmt_e            fmt;
  logic [XLEN-1:0] imm_raw;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign fmt    = fmt_of(opcode);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm_raw)
  );

  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_alu, d_rs1;
  logic            d_bsel, d_pcsel, d_shsel, d_br, d_jmp, d_mr, d_mw, d_rw, d_ill;
  logic [1:0]      d_wb;

  always_comb begin
    d_imm   = imm_raw;
    d_alu   = ALU_ADD;
    d_rs1   = inst[19:15];
    d_bsel  = 1'b0;
    d_pcsel = 1'b0;
    d_shsel = 1'b0;
    d_br    = 1'b0;
    d_jmp   = 1'b0;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_rw    = 1'b0;
    d_ill   = 1'b0;
    d_wb    = WB_ALU;
    case (opcode)
      OP_LOAD:   begin d_bsel = 1'b1; d_mr = 1'b1; d_rw = 1'b1; d_wb = WB_MEM; end
      OP_STORE:  begin d_bsel = 1'b1; d_mw = 1'b1; end
      OP_BRANCH: begin d_pcsel = 1'b1; d_br = 1'b1; end
      OP_JAL:    begin d_bsel = 1'b1; d_pcsel = 1'b1; d_jmp = 1'b1; d_rw = 1'b1; d_wb = WB_PC4; end
      OP_JALR:   begin d_bsel = 1'b1; d_jmp = 1'b1; d_rw = 1'b1; d_wb = WB_PC4; end
      OP_LUI:    begin d_bsel = 1'b1; d_rw = 1'b1; d_rs1 = '0; end
      OP_AUIPC:  begin d_bsel = 1'b1; d_pcsel = 1'b1; d_rw = 1'b1; end
      OP_IMM: begin
        d_bsel  = 1'b1;
        d_rw    = 1'b1;
        d_shsel = (f3 == 3'b001) || (f3 == 3'b101);
        d_alu   = {1'b0, (f3 == 3'b101) && f7[5], f3};
      end
      OP_REG: begin
        d_rw = 1'b1;
        if (f7 == 7'b0000001) begin
          d_alu = {ENABLE_M != 0, 1'b0, f3};
          d_ill = (ENABLE_M == 0);
        end else if (f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          d_alu = {1'b0, f7[5], f3};
        end else begin
          d_ill = 1'b1;
        end
      end
      // ECALL/EBREAK carry no immediate and write nothing
      OP_SYSTEM: begin d_bsel = 1'b1; d_imm = '0; end
      default:   d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_rw  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_br  = 1'b0;
      d_jmp = 1'b0;
    end
    if (inst[11:7] == 5'd0) d_rw = 1'b0;
  end

  logic uses_rs1, uses_rs2, haz, adv;

  assign uses_rs1 = (fmt != FMT_U) && (fmt != FMT_J);
  assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign haz = (HAZARD_DETECT != 0) && id_valid && mem_read && (rd != 5'd0) &&
               ((rd == inst[19:15] && uses_rs1) || (rd == inst[24:20] && uses_rs2));
  assign adv      = !id_valid || ex_ready;
  assign if_ready = adv && !haz && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid      <= 1'b0;
      id_pc         <= '0;
      rd            <= '0;
      rs1           <= '0;
      rs2           <= '0;
      funct3        <= '0;
      imm           <= '0;
      alu_sel       <= '0;
      b_sel         <= 1'b0;
      pc_reg1_sel   <= 1'b0;
      rs2_shamt_sel <= 1'b0;
      is_branch     <= 1'b0;
      is_jump       <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      reg_write     <= 1'b0;
      wb_sel        <= '0;
      illegal       <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (if_valid && !if_ready && !flush && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      // A hazard bubble keeps the load's fields so the consumer is retried next cycle
      if (flush || (haz && ex_ready)) begin
        id_valid <= 1'b0;
      end else if (if_valid && if_ready) begin
        id_valid      <= 1'b1;
        id_pc         <= pc;
        rd            <= inst[11:7];
        rs1           <= d_rs1;
        rs2           <= inst[24:20];
        funct3        <= f3;
        imm           <= d_imm;
        alu_sel       <= d_alu;
        b_sel         <= d_bsel;
        pc_reg1_sel   <= d_pcsel;
        rs2_shamt_sel <= d_shsel;
        is_branch     <= d_br;
        is_jump       <= d_jmp;
        mem_read      <= d_mr;
        mem_write     <= d_mw;
        reg_write     <= d_rw;
        wb_sel        <= d_wb;
        illegal       <= d_ill;
      end else if (adv) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule
